// File: rtl/enable_period_checker.sv
// Measures the spacing of a single-cycle strobe, checks it against EXPECT and
// tracks acquisition/lock, flagging mismatches while locked and loss of strobe.
module enable_period_checker #(
  parameter int EXPECT     = 10,
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_sclr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_period,
  output logic             o_period_vld,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(MISS_LIMIT + 1);

  localparam logic [WIDTH-1:0] CNT_SAT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_PRE = WIDTH'((1 << WIDTH) - 2);
  localparam logic [WIDTH-1:0] EXP_V   = WIDTH'(EXPECT);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);
  localparam logic [SW-1:0]    MISS_V  = SW'(MISS_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [MW-1:0]    match_q, match_d;
  logic [SW-1:0]    miss_q, miss_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             to_q, to_d;

  logic             is_match;
  logic             timeout_ev;
  logic [MW-1:0]    match_inc;
  logic [SW-1:0]    miss_inc;

  assign is_match   = (cnt_q == EXP_V);
  // Fires one cycle before the counter would saturate; a strobe that cycle wins.
  assign timeout_ev = (state_q != ST_IDLE) && !i_en && (cnt_q == CNT_PRE);
  assign match_inc  = match_q + MW'(1);
  assign miss_inc   = miss_q + SW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
    miss_d   = miss_q;
    period_d = period_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    to_d     = 1'b0;

    if (i_en) begin
      cnt_d = WIDTH'(1);
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    if (i_en && (state_q != ST_IDLE)) begin
      period_d = cnt_q;
      vld_d    = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          state_d = ST_ACQ;
          match_d = '0;
        end
      end
      ST_ACQ: begin
        if (i_en) begin
          if (is_match) begin
            match_d = match_inc;
            if (match_inc == LOCK_V) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end else if (timeout_ev) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (i_en) begin
          if (is_match) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc == MISS_V) begin
              state_d = ST_ACQ;
              match_d = '0;
            end
          end
        end else if (timeout_ev) begin
          state_d = ST_IDLE;
          to_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Synchronous clear overrides everything, including a coincident strobe.
    if (i_sclr) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      match_d  = '0;
      miss_d   = '0;
      period_d = '0;
      vld_d    = 1'b0;
      err_d    = 1'b0;
      to_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  assign o_period     = period_q;
  assign o_period_vld = vld_q;
  assign o_locked     = (state_q == ST_LOCKED);
  assign o_err        = err_q;
  assign o_timeout    = to_q;

endmodule

// File: tb/tb_enable_period_checker.sv
// Checks two checker instances (default and small parameters) against a
// timestamp-based model of strobe spacing, with directed and random strobes.
module tb_enable_period_checker;

  logic       clk;
  logic       rst_n;
  logic       sclr;
  logic       en_a, en_b;
  logic [3:0] per_a;
  logic [2:0] per_b;
  logic       vld_a, lck_a, err_a, to_a;
  logic       vld_b, lck_b, err_b, to_b;

  enable_period_checker dut_a (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en_a),
    .o_period(per_a), .o_period_vld(vld_a), .o_locked(lck_a),
    .o_err(err_a), .o_timeout(to_a)
  );

  enable_period_checker #(
    .EXPECT(5), .WIDTH(3), .LOCK_CNT(1), .MISS_LIMIT(2)
  ) dut_b (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en_b),
    .o_period(per_b), .o_period_vld(vld_b), .o_locked(lck_b),
    .o_err(err_b), .o_timeout(to_b)
  );

  localparam int P_EXP  [2] = '{10, 5};
  localparam int P_SAT  [2] = '{15, 7};
  localparam int P_LOCK [2] = '{3, 1};
  localparam int P_MISS [2] = '{2, 2};

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 0;

  // Model: 0 = idle, 1 = acquiring, 2 = locked; strobe times as edge indices.
  int cyc = 0;
  int m_mode [2];
  int m_last [2];
  int m_streak [2];
  int m_miss [2];
  int e_period [2];
  int e_vld [2];
  int e_locked [2];
  int e_err [2];
  int e_to [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_streak[k] = 0; m_miss[k] = 0;
      e_period[k] = 0; e_vld[k] = 0; e_locked[k] = 0; e_err[k] = 0; e_to[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit en, input bit sc);
    int gap, m;
    e_vld[k] = 0; e_err[k] = 0; e_to[k] = 0;
    if (sc) begin
      m_mode[k] = 0;
      e_period[k] = 0;
    end else if (en) begin
      if (m_mode[k] != 0) begin
        gap = cyc - m_last[k];
        m = (gap < P_SAT[k]) ? gap : P_SAT[k];
        e_period[k] = m;
        e_vld[k] = 1;
        if (m_mode[k] == 1) begin
          if (m == P_EXP[k]) begin
            m_streak[k]++;
            if (m_streak[k] == P_LOCK[k]) begin
              m_mode[k] = 2;
              m_miss[k] = 0;
            end
          end else begin
            m_streak[k] = 0;
          end
        end else begin
          if (m == P_EXP[k]) begin
            m_miss[k] = 0;
          end else begin
            e_err[k] = 1;
            m_miss[k]++;
            if (m_miss[k] == P_MISS[k]) begin
              m_mode[k] = 1;
              m_streak[k] = 0;
            end
          end
        end
      end else begin
        m_mode[k] = 1;
        m_streak[k] = 0;
      end
      m_last[k] = cyc;
    end else if (m_mode[k] != 0 && (cyc - m_last[k]) == P_SAT[k] - 1) begin
      e_to[k] = 1;
      m_mode[k] = 0;
    end
    e_locked[k] = (m_mode[k] == 2) ? 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        model_step(0, en_a, sclr);
        model_step(1, en_b, sclr);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("a_period", 32'(per_a), e_period[0]);
        chk("a_vld", 32'(vld_a), e_vld[0]);
        chk("a_locked", 32'(lck_a), e_locked[0]);
        chk("a_err", 32'(err_a), e_err[0]);
        chk("a_timeout", 32'(to_a), e_to[0]);
        chk("b_period", 32'(per_b), e_period[1]);
        chk("b_vld", 32'(vld_b), e_vld[1]);
        chk("b_locked", 32'(lck_b), e_locked[1]);
        chk("b_err", 32'(err_b), e_err[1]);
        chk("b_timeout", 32'(to_b), e_to[1]);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input bit a, input bit b, input bit s);
    en_a = a; en_b = b; sclr = s;
    @(posedge clk);
    #2;
    en_a = 1'b0; en_b = 1'b0; sclr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic gap(input int n, input bit a, input bit b);
    idle(n - 1);
    step(a, b, 0);
  endtask

  function automatic int pick_gap(input int exp, input int sat);
    int r;
    r = $urandom_range(0, 99);
    if (r < 65) return exp;
    else if (r < 80) return $urandom_range(exp - 2, exp + 2);
    else if (r < 88) return $urandom_range(1, 3);
    else return $urandom_range(sat - 2, sat + 4);
  endfunction

  int ca, cb;
  bit ra, rb, rs;

  initial begin
    rst_n = 1'b0; sclr = 1'b0; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_en = 1;
    chk("reset_period", 32'(per_a), 0);
    chk("reset_locked", 32'(lck_a), 0);
    rst_n = 1'b1;

    // Acquire
    idle(4);
    step(1, 0, 0);
    chk("acq_first_no_vld", 32'(vld_a), 0);
    for (int i = 0; i < 3; i++) begin
      gap(10, 1, 0);
      chk("acq_period", 32'(per_a), 10);
      chk("acq_vld", 32'(vld_a), 1);
      chk("acq_no_err", 32'(err_a), 0);
      chk("acq_locked", 32'(lck_a), (i == 2) ? 1 : 0);
    end
    $display("acquire done, locked=%0d", lck_a);

    // Single miss, then loss of lock
    gap(9, 1, 0);
    chk("miss_period", 32'(per_a), 9);
    chk("miss_err", 32'(err_a), 1);
    chk("miss_locked", 32'(lck_a), 1);
    gap(10, 1, 0);
    chk("miss_recover_err", 32'(err_a), 0);
    gap(12, 1, 0);
    chk("loss1_err", 32'(err_a), 1);
    chk("loss1_locked", 32'(lck_a), 1);
    gap(12, 1, 0);
    chk("loss2_err", 32'(err_a), 1);
    chk("loss2_locked", 32'(lck_a), 0);
    for (int i = 0; i < 3; i++) gap(10, 1, 0);
    chk("relock", 32'(lck_a), 1);
    $display("miss/loss/relock done, locked=%0d", lck_a);

    // Timeout
    idle(13);
    chk("to_early", 32'(to_a), 0);
    step(0, 0, 0);
    chk("to_pulse", 32'(to_a), 1);
    chk("to_unlocked", 32'(lck_a), 0);
    chk("to_period_held", 32'(per_a), 10);
    step(0, 0, 0);
    chk("to_single", 32'(to_a), 0);
    idle(5);
    step(1, 0, 0);
    chk("to_restart_no_vld", 32'(vld_a), 0);
    $display("timeout done");

    // Async reset drops an error pulse
    gap(10, 1, 0);
    gap(10, 1, 0);
    gap(10, 1, 0);
    gap(12, 1, 0);
    chk("pre_rst_err", 32'(err_a), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_err_drop", 32'(err_a), 0);
    chk("rst_period_zero", 32'(per_a), 0);
    chk("rst_unlocked", 32'(lck_a), 0);
    step(0, 0, 0);
    rst_n = 1'b1;

    // Async reset mid-acquisition
    step(1, 0, 0);
    gap(10, 1, 0);
    chk("acq_vld_pre_rst", 32'(vld_a), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_vld_drop", 32'(vld_a), 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    $display("async reset done");

    // Clear coincident with strobe
    step(1, 0, 0);
    gap(10, 1, 0);
    idle(9);
    step(1, 0, 1);
    chk("sclr_period", 32'(per_a), 0);
    chk("sclr_vld", 32'(vld_a), 0);
    gap(10, 1, 0);
    chk("sclr_next_no_vld", 32'(vld_a), 0);
    gap(10, 1, 0);
    chk("sclr_then_vld", 32'(vld_a), 1);
    $display("sync clear done");

    // Small-parameter instance
    step(0, 1, 0);
    gap(5, 0, 1);
    chk("b_lock_period", 32'(per_b), 5);
    chk("b_lock", 32'(lck_b), 1);
    gap(6, 0, 1);
    chk("b_gap6_period", 32'(per_b), 6);
    chk("b_gap6_err", 32'(err_b), 1);
    idle(5);
    chk("b_to_early", 32'(to_b), 0);
    step(0, 0, 0);
    chk("b_to_pulse", 32'(to_b), 1);
    chk("b_to_unlocked", 32'(lck_b), 0);
    step(0, 1, 0);
    chk("b_restart_no_vld", 32'(vld_b), 0);
    gap(5, 0, 1);
    chk("b_relock", 32'(lck_b), 1);
    $display("small-parameter instance done");

    // Random strobes on both instances
    ca = pick_gap(10, 15);
    cb = pick_gap(5, 7);
    for (int i = 0; i < 4000; i++) begin
      ra = 1'b0; rb = 1'b0;
      ca--; cb--;
      if (ca <= 0) begin ra = 1'b1; ca = pick_gap(10, 15); end
      if (cb <= 0) begin rb = 1'b1; cb = pick_gap(5, 7); end
      rs = ($urandom_range(0, 399) == 0);
      step(ra, rb, rs);
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        step(0, 0, 0);
        rst_n = 1'b1;
      end
    end
    $display("random phase done");

    @(negedge clk);
    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
